// File: rtl/uart_rx_bus.sv
// uart_rx_bus: bus-mapped 8N1 UART receiver with a small byte FIFO.
// Serial input rx is double-flopped, then a four-state FSM samples mid-bit
// using a baud down-counter that fires on terminal count zero.
// Optional build macro UART_RX_IRQ_EN adds the irq port and the irq_en bit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle, waiting for synced rx low
//   S_START | timing half a bit to re-check the start bit
//   S_DATA  | sampling 8 data bits, LSB first, one per DIV cycles
//   S_STOP  | sampling stop bit: high pushes the byte, low flags ferr
module uart_rx_bus #(
  parameter int CLK_MHZ = 25,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        rx
`ifdef UART_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV   = (CLK_MHZ * 1000000) / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [CNT_W-1:0]   FULL_LD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   HALF_LD = CNT_W'(DIV / 2 - 1);
  localparam logic [FIFO_AW:0]   DEPTH_V = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic               r_rx_meta;
  logic               r_rx_sync;
  state_t             r_state;
  logic [CNT_W-1:0]   r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_ovr;
  logic               r_ferr;

  logic               w_tick;
  logic               w_push_req;
  logic               w_ferr_set;
  logic               w_empty;
  logic               w_full;
  logic               w_rd;
  logic               w_pop;
  logic               w_push;
  logic               w_ovr_set;
  logic               w_st_wr;
  logic               w_irq_en;
  logic [7:0]         w_head;
  logic [3:0]         w_cnt4;
  logic [31:0]        w_status;
  logic               w_unused_din;

  assign w_tick     = (r_baud_cnt == '0);
  assign w_push_req = (r_state == S_STOP) && w_tick && r_rx_sync;
  assign w_ferr_set = (r_state == S_STOP) && w_tick && !r_rx_sync;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH_V);
  assign w_rd      = ce && !we;
  assign w_pop     = w_rd && (addr == 4'h8) && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovr_set = w_push_req && w_full && !w_pop;
  assign w_st_wr   = ce && we && (addr == 4'hC);

  assign w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_cnt4   = 4'(r_cnt);
  assign w_status = {20'h0, w_irq_en, 3'b000, w_cnt4, r_ferr, r_ovr, 1'b0, !w_empty};

  // Only a few din bits are architecturally meaningful.
  assign w_unused_din = ^din;

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM: start detect, mid-bit sampling and byte assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_state    <= S_START;
            r_baud_cnt <= HALF_LD;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else if (!r_rx_sync) begin
            r_state    <= S_DATA;
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= FULL_LD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_shift[r_bit_idx] <= r_rx_sync;
            r_baud_cnt         <= FULL_LD;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovr_set)                r_ovr <= 1'b1;
      else if (w_st_wr && din[2])   r_ovr <= 1'b0;
      if (w_ferr_set)               r_ferr <= 1'b1;
      else if (w_st_wr && din[3])   r_ferr <= 1'b0;
    end
  end

`ifdef UART_RX_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;

  // Interrupt enable register and registered interrupt request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_st_wr) r_irq_en <= din[11];
      r_irq <= r_irq_en && (!w_empty || r_ovr || r_ferr);
    end
  end
`else
  assign w_irq_en = 1'b0;
`endif

  // Combinational read mux; anything other than a mapped read returns zero.
  always_comb begin
    dout = 32'h0;
    if (w_rd) begin
      case (addr)
        4'h8:    dout = {23'h0, !w_empty, w_head};
        4'hC:    dout = w_status;
        default: dout = 32'h0;
      endcase
    end
  end

endmodule
